// File: rtl/rom_loader.sv
// Streams a byte-wide ROM image into a word-wide memory, packing four
// consecutive bytes little-endian per 32-bit write.
module rom_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte,
  input  logic        rom_done,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  input  logic        mem_ready,
  output logic        busy,
  output logic        finished,
  output logic [31:0] byte_count,
  output logic [1:0]  dbg_state
);

  // Handshake: a word transfers on every rising edge where mem_write and
  // mem_ready are both high; mem_write/mem_address/mem_data hold until then.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_rom_address;
  logic [31:0] r_byte_count;
  logic [31:0] r_pack;
  logic [29:0] r_word_index;
  logic        r_last;
  logic        r_mem_write;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_data;
  logic        r_busy;
  logic        r_finished;

  logic [1:0]  w_lane;
  logic [31:0] w_pack_next;
  logic [31:0] w_word_addr;

  assign w_lane      = r_rom_address[1:0];
  assign w_word_addr = BASE_ADDRESS + {r_word_index, 2'b00};

  always_comb begin
    w_pack_next = r_pack;
    w_pack_next[{w_lane, 3'b000} +: 8] = rom_byte;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_rom_address <= 32'd0;
      r_byte_count  <= 32'd0;
      r_pack        <= 32'd0;
      r_word_index  <= 30'd0;
      r_last        <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= 32'd0;
      r_mem_data    <= 32'd0;
      r_busy        <= 1'b0;
      r_finished    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_rom_address <= 32'd0;
            r_byte_count  <= 32'd0;
            r_pack        <= 32'd0;
            r_word_index  <= 30'd0;
            r_last        <= 1'b0;
            r_finished    <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_pack       <= w_pack_next;
          r_byte_count <= r_byte_count + 32'd1;
          // A word closes on lane 3 or on the last ROM byte; unfilled lanes stay zero.
          if (w_lane == 2'd3 || rom_done) begin
            r_last        <= rom_done;
            r_mem_write   <= 1'b1;
            r_mem_address <= w_word_addr;
            r_mem_data    <= w_pack_next;
            r_state       <= S_WRITE;
          end else begin
            r_rom_address <= r_rom_address + 32'd1;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            r_mem_write <= 1'b0;
            if (r_last) begin
              r_busy     <= 1'b0;
              r_finished <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_rom_address <= r_rom_address + 32'd1;
              r_word_index  <= r_word_index + 30'd1;
              r_pack        <= 32'd0;
              r_state       <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_address = r_rom_address;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign busy        = r_busy;
  assign finished    = r_finished;
  assign byte_count  = r_byte_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: full image load, stalled write, mid-write
// reset, ignored/accepted restarts, and a one-byte image at a non-zero base.
module tb_rom_loader;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] rom_address;
  logic [7:0]  rom_byte;
  logic        rom_done;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        busy;
  logic        finished;
  logic [31:0] byte_count;
  logic [1:0]  dbg_state;

  logic        start1;
  logic [31:0] rom_address1;
  logic [7:0]  rom_byte1;
  logic        rom_done1;
  logic        mem_write1;
  logic [31:0] mem_address1;
  logic [31:0] mem_data1;
  logic        mem_ready1;
  logic        busy1;
  logic        finished1;
  logic [31:0] byte_count1;
  logic [1:0]  dbg_state1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  rom [0:511];
  logic [31:0] last_addr;
  logic [31:0] exp_q [$];
  logic [31:0] cap_addr [$];
  logic [31:0] cap_data [$];
  int          cap_cyc [$];
  logic [31:0] cap1_addr [$];
  logic [31:0] cap1_data [$];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rom_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .rom_address(rom_address), .rom_byte(rom_byte), .rom_done(rom_done),
    .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data),
    .mem_ready(mem_ready), .busy(busy), .finished(finished),
    .byte_count(byte_count), .dbg_state(dbg_state)
  );

  rom_loader #(.BASE_ADDRESS(32'h1000)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1),
    .rom_address(rom_address1), .rom_byte(rom_byte1), .rom_done(rom_done1),
    .mem_write(mem_write1), .mem_address(mem_address1), .mem_data(mem_data1),
    .mem_ready(mem_ready1), .busy(busy1), .finished(finished1),
    .byte_count(byte_count1), .dbg_state(dbg_state1)
  );

  always_comb begin
    rom_byte  = (rom_address < 32'd512) ? rom[rom_address[8:0]] : 8'h00;
    rom_done  = (rom_address == last_addr);
    rom_byte1 = (rom_address1 == 32'd0) ? 8'hA7 : 8'h55;
    rom_done1 = (rom_address1 == 32'd0);
  end

  // Records every accepted write.
  always @(posedge clock) begin
    if (mem_write && mem_ready) begin
      cap_addr.push_back(mem_address);
      cap_data.push_back(mem_data);
      cap_cyc.push_back(cyc);
    end
    if (mem_write1 && mem_ready1) begin
      cap1_addr.push_back(mem_address1);
      cap1_data.push_back(mem_data1);
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (finished !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(finished), 32'd1);
  endtask

  // Scoreboard: rebuild expected words from the ROM image and drain captures.
  task automatic compare_load(input int n_bytes);
    int words;
    logic [31:0] w;
    logic [31:0] obs_a;
    logic [31:0] obs_d;
    words = (n_bytes + 3) / 4;
    exp_q.delete();
    for (int i = 0; i < words; i++) begin
      w = 32'd0;
      for (int n = 0; n < 4; n++)
        if (4 * i + n < n_bytes) w[8*n +: 8] = rom[4*i+n];
      exp_q.push_back(w);
    end
    chk("write_count", 32'(cap_addr.size()), 32'(words));
    for (int i = 0; i < words; i++) begin
      obs_a = 32'hxxxxxxxx;
      obs_d = 32'hxxxxxxxx;
      if (cap_addr.size() > 0) begin
        obs_a = cap_addr.pop_front();
        obs_d = cap_data.pop_front();
      end
      chk("word_addr", obs_a, 32'(4 * i));
      chk("word_data", obs_d, exp_q.pop_front());
    end
    chk("byte_count_end", byte_count, 32'(n_bytes));
    chk("finished_end", 32'(finished), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    cap_cyc.delete();
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_rom_address"}, rom_address, 32'd0);
    chk({pfx, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({pfx, "_mem_address"}, mem_address, 32'd0);
    chk({pfx, "_mem_data"}, mem_data, 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_finished"}, 32'(finished), 32'd0);
    chk({pfx, "_byte_count"}, byte_count, 32'd0);
    chk({pfx, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [31:0] h_addr;
    logic [31:0] h_data;
    logic [31:0] h_rom;

    for (int i = 0; i < 512; i++) rom[i] = 8'(i * 37 + 11);
    rom[0] = 8'h00; rom[1] = 8'h0E; rom[2] = 8'h14; rom[3] = 8'h3D;
    last_addr  = 32'd422;
    reset_n    = 1'b0;
    start      = 1'b0;
    start1     = 1'b0;
    mem_ready  = 1'b0;
    mem_ready1 = 1'b1;

    // Reset state
    repeat (3) tick();
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    repeat (2) tick();
    chk("idle_no_start", 32'(busy), 32'd0);

    // 423-byte image, mem_ready tied high
    mem_ready = 1'b1;
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rom_address", rom_address, 32'd0);
    chk("start_byte_count", byte_count, 32'd0);
    wait_done(1000);
    if (cap_cyc.size() >= 106) begin
      chk("first_word_data", cap_data[0], 32'h3D140E00);
      chk("last_word_addr", cap_addr[105], 32'h1A4);
      chk("last_word_data", cap_data[105], {8'h00, rom[422], rom[421], rom[420]});
      chk("throughput_0", 32'(cap_cyc[1] - cap_cyc[0]), 32'd5);
      chk("throughput_50", 32'(cap_cyc[50] - cap_cyc[49]), 32'd5);
    end
    compare_load(423);
    repeat (3) tick();
    chk("done_hold_count", byte_count, 32'd423);
    chk("done_hold_fin", 32'(finished), 32'd1);

    // 12-byte image with a 7-cycle stall on the first write, restart ignored mid-load
    last_addr = 32'd11;
    mem_ready = 1'b0;
    pulse_start();
    chk("restart_from_done_fin", 32'(finished), 32'd0);
    n = 0;
    while (mem_write !== 1'b1 && n < 20) begin tick(); n++; end
    chk("stall_write_seen", 32'(mem_write), 32'd1);
    h_addr = mem_address;
    h_data = mem_data;
    h_rom  = rom_address;
    chk("stall_addr0", h_addr, 32'd0);
    chk("stall_data0", h_data, {rom[3], rom[2], rom[1], rom[0]});
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stall_mem_write", 32'(mem_write), 32'd1);
      chk("stall_mem_address", mem_address, h_addr);
      chk("stall_mem_data", mem_data, h_data);
      chk("stall_rom_address", rom_address, h_rom);
    end
    chk("stall_no_handshake", 32'(cap_addr.size()), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("after_hs_mem_write", 32'(mem_write), 32'd0);
    chk("after_hs_rom_address", rom_address, 32'd4);
    chk("after_hs_count", 32'(cap_addr.size()), 32'd1);
    pulse_start();
    chk("ignored_start_count", byte_count, 32'd5);
    chk("ignored_start_rom", rom_address, 32'd5);
    wait_done(100);
    compare_load(12);

    // Restart from DONE clears finished and byte_count
    pulse_start();
    chk("restart_finished", 32'(finished), 32'd0);
    chk("restart_byte_count", byte_count, 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_rom_address", rom_address, 32'd0);
    wait_done(100);
    compare_load(12);

    // Reset during the WRITE of word 3
    last_addr = 32'd422;
    pulse_start();
    n = 0;
    while (cap_addr.size() < 3 && n < 100) begin tick(); n++; end
    mem_ready = 1'b0;
    n = 0;
    while (mem_write !== 1'b1 && n < 20) begin tick(); n++; end
    chk("word3_write", 32'(mem_write), 32'd1);
    chk("word3_addr", mem_address, 32'h0C);
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    tick();
    tick();
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    repeat (10) tick();
    chk("no_resume_writes", 32'(cap_addr.size()), 32'd3);
    chk_zero_outputs("post_reset_idle");
    cap_addr.delete();
    cap_data.delete();
    cap_cyc.delete();
    pulse_start();
    chk("reload_rom_address", rom_address, 32'd0);
    wait_done(1000);
    compare_load(423);

    // One-byte image at BASE_ADDRESS 0x1000
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (finished1 !== 1'b1 && n < 50) begin tick(); n++; end
    chk("b1_finished", 32'(finished1), 32'd1);
    chk("b1_write_count", 32'(cap1_addr.size()), 32'd1);
    if (cap1_addr.size() > 0) begin
      chk("b1_addr", cap1_addr[0], 32'h1000);
      chk("b1_data", cap1_data[0], 32'h000000A7);
    end
    chk("b1_byte_count", byte_count1, 32'd1);
    chk("b1_busy", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'd0, giving the destination memory byte address of the first loaded word.
REQ-002 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: reset, asynchronous assertion, active-low.
REQ-004 SHALL have port start, input, 1: single-cycle request to begin a load.
REQ-005 SHALL have port rom_address, output, 32: byte address driven to the ROM.
REQ-006 SHALL have port rom_byte, input, 8: combinational ROM data for rom_address, valid in the same cycle.
REQ-007 SHALL have port rom_done, input, 1: high when rom_address is the last ROM byte; that byte is part of the image.
REQ-008 SHALL have port mem_write, output, 1: write request to destination memory.
REQ-009 SHALL have port mem_address, output, 32: destination byte address, word aligned.
REQ-010 SHALL have port mem_data, output, 32: packed word, little-endian (byte at rom_address 4k+n in bits 8n+7:8n).
REQ-011 SHALL have port mem_ready, input, 1: memory accepts the write in any cycle where mem_write and mem_ready are both high.
REQ-012 SHALL have port busy, output, 1: load in progress.
REQ-013 SHALL have port finished, output, 1: last load completed.
REQ-014 SHALL have port byte_count, output, 32: number of ROM bytes consumed in the current or last load.

Function
REQ-015 SHALL implement states IDLE, FETCH, WRITE, DONE.
REQ-016 IDLE/DONE + start SHALL clear rom_address, byte_count, packing register and finished, then enter FETCH next cycle; busy high from that cycle.
REQ-017 FETCH SHALL, each cycle, latch rom_byte into lane rom_address[1:0] of the packing register and increment byte_count.
REQ-018 FETCH SHALL increment rom_address and stay in FETCH when lane is 0..2 and rom_done is low.
REQ-019 FETCH SHALL enter WRITE when lane is 3 or rom_done is high, recording a last flag equal to rom_done.
REQ-020 Lanes not filled before rom_done SHALL be zero in mem_data.
REQ-021 WRITE SHALL hold mem_write high, mem_address = BASE_ADDRESS + 4*word_index, mem_data stable, until the mem_ready handshake cycle.
REQ-022 rom_address SHALL NOT change in WRITE.
REQ-023 On handshake: last clear -> increment rom_address and word_index, clear packing register, enter FETCH; last set -> enter DONE.
REQ-024 mem_write SHALL deassert in the cycle after the handshake; exactly one handshake per word.
REQ-025 DONE SHALL hold busy low, finished high, byte_count frozen, until a new start.
REQ-026 start SHALL be ignored while busy.
REQ-027 rom_done at rom_address 0 SHALL produce a single word with lane 0 only; byte_count 1.
REQ-028 mem_ready high continuously SHALL give throughput of one word per 5 cycles (4 FETCH + 1 WRITE).
REQ-029 rom_address SHALL wrap 32'hFFFFFFFF to 0 without error; no rom_done means the load does not terminate.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE and all outputs to 0 (rom_address, mem_write, mem_address, mem_data, busy, finished, byte_count), including mid-load and mid-WRITE.
REQ-031 After reset release, the block SHALL stay IDLE until start; an interrupted load is not resumed.

Verification
REQ-032 423-byte ROM (rom_done at 422), mem_ready tied high, start -> 106 writes at 0x000..0x1A4, final word bytes 420..422 plus a zero top byte, byte_count 423, finished high.
REQ-033 Bytes 0x00,0x0E,0x14,0x3D at addresses 0..3 -> first write mem_data 32'h3D140E00 at mem_address BASE_ADDRESS.
REQ-034 mem_ready low for 7 cycles during a write -> mem_write, mem_address, mem_data, rom_address stable for all 8 cycles; one handshake.
REQ-035 BASE_ADDRESS=32'h1000, rom_done at address 0 -> single write at 0x1000, mem_data = {24'd0, byte0}, byte_count 1.
REQ-036 reset_n pulsed low in the WRITE of word 3 -> outputs 0 asynchronously, no further writes; new start reloads from address 0.
REQ-037 start pulsed mid-load and again in DONE -> first ignored; second restarts with finished cleared and byte_count reset.
